// File: rtl/mt9v032_embed.sv
// MT9V032 embedded-sync encoder: pixels plus sof/eol/eof flags in, a 10-bit word stream with sync codes out.
// Latency: frame start is 5 edges from the sof pixel to the pixel word; a line start is 2 edges; steady pixels take 1 edge.
// Backpressure: in_ready is high only while emitting pixels. An input gap inside a line emits black (4) and sets underrun.
module mt9v032_embed #(
   parameter int HBLANK = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [9:0] in_px,
   input  logic       in_sof,
   input  logic       in_eol,
   input  logic       in_eof,
   output logic [9:0] data_out,
   output logic       err,
   output logic       underrun
);

   typedef enum logic [2:0] {IDLE, FS1, FS2, LS, PIX, LE, BLANK} state_t;

   localparam logic [7:0] HB = 8'(HBLANK);

   state_t     r_state;
   logic       r_frame;
   logic       r_code_eof;
   logic [7:0] r_cnt;
   logic [9:0] r_data;
   logic       r_err;
   logic       r_under;

   state_t     w_state_nxt;
   logic       w_frame_nxt;
   logic       w_code_eof_nxt;
   logic [7:0] w_cnt_nxt;
   logic [9:0] w_data_nxt;
   logic       w_err_set;
   logic       w_under_set;
   logic       w_drop;

   // Reserved values (0..3 and the 1023 marker) must never appear as pixel data.
   function automatic logic [9:0] map_px(input logic [9:0] p);
      if (p <= 10'd4)        return 10'd4;
      else if (p == 10'd1023) return 10'd1022;
      else                   return p;
   endfunction

   // Next state and next word; the state names the word to emit on the coming edge.
   always_comb begin
      w_state_nxt    = r_state;
      w_frame_nxt    = r_frame;
      w_code_eof_nxt = r_code_eof;
      w_cnt_nxt      = r_cnt;
      w_data_nxt     = 10'd0;
      w_err_set      = 1'b0;
      w_under_set    = 1'b0;
      w_drop         = 1'b0;
      case (r_state)
         IDLE: begin
            if (in_valid) begin
               if (in_sof) begin
                  // A second sof inside an open frame is flagged, then restarts the frame.
                  w_err_set   = r_frame;
                  w_frame_nxt = 1'b1;
                  w_data_nxt  = 10'd1023;
                  w_state_nxt = FS1;
               end else if (r_frame) begin
                  w_data_nxt  = 10'd1;
                  w_state_nxt = PIX;
               end else begin
                  // A stray pixel outside a frame is discarded so the stream cannot deadlock.
                  w_err_set = 1'b1;
                  w_drop    = 1'b1;
               end
            end
         end
         FS1: w_state_nxt = FS2;
         FS2: begin
            w_data_nxt  = 10'd1023;
            w_state_nxt = LS;
         end
         LS: begin
            w_data_nxt  = 10'd1;
            w_state_nxt = PIX;
         end
         PIX: begin
            if (in_valid) begin
               w_data_nxt = map_px(in_px);
               if (in_eol) begin
                  w_code_eof_nxt = in_eof;
                  w_state_nxt    = LE;
               end
            end else begin
               w_data_nxt  = 10'd4;
               w_under_set = 1'b1;
            end
         end
         LE: begin
            w_data_nxt = r_code_eof ? 10'd3 : 10'd2;
            if (r_code_eof) w_frame_nxt = 1'b0;
            w_cnt_nxt   = HB;
            w_state_nxt = (HB == 8'd0) ? IDLE : BLANK;
         end
         BLANK: begin
            w_cnt_nxt = r_cnt - 8'd1;
            if (r_cnt <= 8'd1) w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // Gated by rst_n so in_ready drops at once when reset asserts.
   assign in_ready = rst_n & ((r_state == PIX) | w_drop);

   // State, output word and sticky flags.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= IDLE;
         r_frame    <= 1'b0;
         r_code_eof <= 1'b0;
         r_cnt      <= 8'd0;
         r_data     <= 10'd0;
         r_err      <= 1'b0;
         r_under    <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_frame    <= w_frame_nxt;
         r_code_eof <= w_code_eof_nxt;
         r_cnt      <= w_cnt_nxt;
         r_data     <= w_data_nxt;
         r_err      <= r_err | w_err_set;
         r_under    <= r_under | w_under_set;
      end
   end

   assign data_out = r_data;
   assign err      = r_err;
   assign underrun = r_under;

endmodule

// File: tb/tb_mt9v032_embed.sv
`timescale 1ns/1ps
module tb_mt9v032_embed;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n;
   logic       in_valid;
   logic [9:0] in_px;
   logic       in_sof, in_eol, in_eof;
   logic       sel;

   logic       v2, v0, rdy2, rdy0, err2, err0, und2, und0;
   logic [9:0] d2, d0;
   logic       rdy, errf, undf;
   logic [9:0] dout;

   assign v2   = in_valid & ~sel;
   assign v0   = in_valid & sel;
   assign rdy  = sel ? rdy0 : rdy2;
   assign dout = sel ? d0 : d2;
   assign errf = sel ? err0 : err2;
   assign undf = sel ? und0 : und2;

   mt9v032_embed #(.HBLANK(2)) u_hb2 (
      .clk(clk), .rst_n(rst_n), .in_valid(v2), .in_ready(rdy2), .in_px(in_px),
      .in_sof(in_sof), .in_eol(in_eol), .in_eof(in_eof),
      .data_out(d2), .err(err2), .underrun(und2));

   mt9v032_embed #(.HBLANK(0)) u_hb0 (
      .clk(clk), .rst_n(rst_n), .in_valid(v0), .in_ready(rdy0), .in_px(in_px),
      .in_sof(in_sof), .in_eol(in_eol), .in_eof(in_eof),
      .data_out(d0), .err(err0), .underrun(und0));

   typedef struct {
      int px;
      bit sof;
      bit eol;
      bit eof;
   } pix_t;

   pix_t stim[$];
   int   exp_q[$];
   int   rec_q[$];
   bit   rec = 1'b0;
   int   gap_at = -1;
   int   gap_n  = 0;
   int   n_vec  = 0;
   int   n_bad  = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_vec++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got %0d want %0d", tag, got, want);
      end
   endtask

   // Output capture, sampled 1 ns after each rising edge.
   always @(posedge clk) begin
      #1;
      if (rec) rec_q.push_back(int'(dout));
   end

   function automatic int map_px(input int p);
      if (p <= 4) return 4;
      if (p == 1023) return 1022;
      return p;
   endfunction

   // Expected word stream for the stimulus list with input always ready
   // (apart from the optional gap): markers, line starts, mapped pixels, end codes, blanking.
   task automatic model(input int hb);
      bit line_open;
      line_open = 1'b0;
      exp_q.delete();
      foreach (stim[i]) begin
         if (stim[i].sof) begin
            exp_q.push_back(1023); exp_q.push_back(0);
            exp_q.push_back(1023); exp_q.push_back(1);
            line_open = 1'b1;
         end else if (!line_open) begin
            exp_q.push_back(1);
            line_open = 1'b1;
         end
         if (i == gap_at) repeat (gap_n) exp_q.push_back(4);
         exp_q.push_back(map_px(stim[i].px));
         if (stim[i].eol) begin
            exp_q.push_back(stim[i].eof ? 3 : 2);
            repeat (hb) exp_q.push_back(0);
            line_open = 1'b0;
         end
      end
      repeat (3) exp_q.push_back(0);
   endtask

   // Present one pixel and hold it until it is accepted; entered and left just after a falling edge.
   task automatic push(input pix_t p, output bit ok);
      in_valid = 1'b1;
      in_px    = p.px[9:0];
      in_sof   = p.sof;
      in_eol   = p.eol;
      in_eof   = p.eof;
      ok       = 1'b0;
      for (int k = 0; k < 40 && !ok; k++) begin
         #1;
         if (rdy === 1'b1) ok = 1'b1;
         @(negedge clk);
      end
   endtask

   task automatic idle_inputs();
      in_valid = 1'b0;
      in_sof   = 1'b0;
      in_eol   = 1'b0;
      in_eof   = 1'b0;
   endtask

   task automatic drive_all(input string tag);
      bit ok;
      foreach (stim[i]) begin
         if (i == gap_at) begin
            in_valid = 1'b0;
            repeat (gap_n) @(negedge clk);
         end
         push(stim[i], ok);
         if (!ok) begin
            chk({tag, "_rdy_timeout"}, 0, 1);
            break;
         end
      end
      idle_inputs();
   endtask

   task automatic run_check(input string tag, input int hb);
      model(hb);
      rec_q.delete();
      rec = 1'b1;
      drive_all(tag);
      for (int k = 0; k < 200 && rec_q.size() < exp_q.size(); k++) @(negedge clk);
      rec = 1'b0;
      foreach (exp_q[i]) chk(tag, (i < rec_q.size()) ? rec_q[i] : -1, exp_q[i]);
      gap_at = -1;
      gap_n  = 0;
      repeat (4) @(negedge clk);
   endtask

   task automatic add_px(input int px, input bit sof, input bit eol, input bit eof);
      pix_t p;
      p.px = px; p.sof = sof; p.eol = eol; p.eof = eof;
      stim.push_back(p);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int   dec[$];
      int   lines, cnt, nl, nper;
      bit   fv, lv, ok;
      int   wlen[4];
      pix_t p;

      sel   = 1'b0;
      rst_n = 1'b0;
      in_px = '0;
      idle_inputs();
      repeat (3) @(negedge clk);
      chk("rst_dout", d2, 0);
      chk("rst_rdy", rdy2, 0);
      chk("rst_err", err2, 0);
      chk("rst_und", und2, 0);
      rst_n = 1'b1;
      @(negedge clk);

      // Two-line frame, HBLANK = 2.
      stim.delete();
      add_px(10, 1, 0, 0); add_px(20, 0, 0, 0); add_px(30, 0, 1, 0);
      add_px(40, 0, 0, 0); add_px(50, 0, 0, 0); add_px(60, 0, 1, 1);
      run_check("frame2x3", 2);
      chk("frame2x3_err", errf, 0);
      chk("frame2x3_und", undf, 0);

      // Reserved pixel values.
      stim.delete();
      add_px(0, 1, 0, 0); add_px(1, 0, 0, 0); add_px(2, 0, 0, 0); add_px(3, 0, 0, 0);
      add_px(4, 0, 0, 0); add_px(5, 0, 0, 0); add_px(1022, 0, 0, 0); add_px(1023, 0, 1, 1);
      run_check("mapping", 2);

      // One-pixel frame.
      stim.delete();
      add_px(777, 1, 1, 1);
      run_check("onepix", 2);

      // Random frame: 3 lines of random length, full pixel range.
      stim.delete();
      for (int l = 0; l < 3; l++) begin
         nper = $urandom_range(1, 6);
         for (int j = 0; j < nper; j++)
            add_px($urandom_range(0, 1023), (l == 0 && j == 0), (j == nper - 1), (l == 2 && j == nper - 1));
      end
      run_check("rand_frame", 2);
      chk("rand_err", errf, 0);

      // Loopback through a behavioural embedded-sync decoder, HBLANK = 0.
      sel = 1'b1;
      @(negedge clk);
      stim.delete();
      for (int l = 0; l < 4; l++)
         for (int j = 0; j < 8; j++)
            add_px($urandom_range(5, 1022), (l == 0 && j == 0), (j == 7), (l == 3 && j == 7));
      run_check("loop_stream", 0);
      dec.delete();
      fv = 1'b0; lv = 1'b0; lines = 0; cnt = 0; nl = 0;
      for (int i = 0; i < rec_q.size(); i++) begin
         if (rec_q[i] == 1023 && i + 2 < rec_q.size() && rec_q[i+1] == 0 && rec_q[i+2] == 1023) begin
            fv = 1'b1;
            i  = i + 2;
         end else if (rec_q[i] == 1 && fv && !lv) begin
            lv  = 1'b1;
            cnt = 0;
         end else if ((rec_q[i] == 2 || rec_q[i] == 3) && lv) begin
            lv = 1'b0;
            if (nl < 4) wlen[nl] = cnt;
            nl++;
            if (rec_q[i] == 3) fv = 1'b0;
         end else if (rec_q[i] >= 4 && lv) begin
            dec.push_back(rec_q[i]);
            cnt++;
         end
      end
      chk("loop_lines", nl, 4);
      for (int l = 0; l < 4 && l < nl; l++) chk("loop_linelen", wlen[l], 8);
      chk("loop_npx", dec.size(), 32);
      foreach (stim[i]) chk("loop_px", (i < dec.size()) ? dec[i] : -1, stim[i].px);
      chk("loop_fv_end", fv, 0);
      chk("loop_lv_end", lv, 0);
      sel = 1'b0;
      @(negedge clk);

      // Two-cycle input gap inside a line.
      stim.delete();
      add_px(100, 1, 0, 0); add_px(200, 0, 0, 0); add_px(300, 0, 1, 0);
      add_px(400, 0, 1, 1);
      gap_at = 2;
      gap_n  = 2;
      run_check("underrun", 2);
      chk("underrun_flag", undf, 1);
      chk("underrun_err", errf, 0);

      // Stray pixel outside a frame is dropped in one cycle.
      do_reset();
      chk("post_rst_und", undf, 0);
      rec_q.delete();
      rec      = 1'b1;
      in_valid = 1'b1;
      in_px    = 10'd77;
      #1;
      chk("drop_rdy", rdy, 1);
      @(negedge clk);
      idle_inputs();
      #1;
      chk("drop_rdy_low", rdy, 0);
      repeat (2) @(negedge clk);
      rec = 1'b0;
      for (int i = 0; i < 3; i++) chk("drop_dout", (i < rec_q.size()) ? rec_q[i] : -1, 0);
      chk("drop_err", errf, 1);

      // sof inside an open frame restarts the frame without an end code.
      do_reset();
      chk("post_rst_err", errf, 0);
      stim.delete();
      add_px(50, 1, 1, 0); add_px(60, 1, 1, 1);
      run_check("sof_in_frame", 2);
      chk("sof_in_frame_err", errf, 1);

      // Reset asserted while pixel 2 of a line is presented.
      do_reset();
      p.px = 11; p.sof = 1; p.eol = 0; p.eof = 0;
      push(p, ok);
      chk("mid_rst_p0", ok, 1);
      p.px = 12; p.sof = 0;
      push(p, ok);
      chk("mid_rst_p1", ok, 1);
      in_valid = 1'b1;
      in_px    = 10'd13;
      #1;
      chk("mid_rst_rdy_before", rdy, 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_dout", dout, 0);
      chk("mid_rst_rdy", rdy, 0);
      idle_inputs();
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      stim.delete();
      for (int j = 0; j < 5; j++) add_px($urandom_range(0, 1023), (j == 0), (j == 4), (j == 4));
      run_check("after_rst", 2);
      chk("after_rst_err", errf, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
